// File: rtl/scan_pkg.sv
// Shared types and helpers for the decoder scan sequencer.
// The sequencer walks the four 2-to-4 decoder lines and skips masked ones.
package scan_pkg;

  localparam int NUM_LINES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FREE   = 2'b01,
    SINGLE = 2'b10
  } state_t;

  // The search runs from the farthest candidate down to the nearest.
  // The closest enabled line overwrites the result last, so it wins.
  // When only the current line is enabled, the search wraps back onto it.
  function automatic logic [SEL_W-1:0] next_index(
    input logic [SEL_W-1:0]     idx,
    input logic [NUM_LINES-1:0] mask
  );
    logic [SEL_W-1:0] cand;
    next_index = idx;
    for (int k = NUM_LINES; k >= 1; k--) begin
      cand = idx + SEL_W'(k);
      if (mask[cand]) next_index = cand;
    end
  endfunction

endpackage

// File: rtl/step_sync.sv
// Two-flop synchronizer for the external step input.
// A registered rising-edge detector follows it and emits a one-cycle step_pulse.
module step_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic step,
  output logic step_pulse
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta       <= 1'b0;
      sync       <= 1'b0;
      sync_d     <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      meta       <= step;
      sync       <= meta;
      sync_d     <= sync;
      step_pulse <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/scan_sequencer.sv
// Generates the {a, b} select for a 2-to-4 decoder, stepping through enabled lines.
// It advances either from a free-running prescaler or from synchronized step pulses.
module scan_sequencer
  import scan_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int DIV_W    = 17
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 step,
  input  logic [NUM_LINES-1:0] enable_mask,
  output logic                 a,
  output logic                 b,
  output logic                 sel_valid,
  output logic                 tick,
  output logic                 wrap
);

  localparam logic [DIV_W-1:0] TERMINAL = DIV_W'(TICK_DIV - 1);

  state_t           state;
  state_t           nxt_state;
  logic [DIV_W-1:0] presc;
  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] sel;
  logic [SEL_W-1:0] cand_idx;
  logic [SEL_W-1:0] idx_next;
  logic             step_pulse;
  logic             state_change;
  logic             terminal;
  logic             adv_req;
  logic             advance;

  step_sync u_step_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (step),
    .step_pulse (step_pulse)
  );

  always_comb begin
    nxt_state = IDLE;
    if (en) nxt_state = mode ? SINGLE : FREE;
  end

  assign state_change = (nxt_state != state);
  assign terminal     = (presc == TERMINAL);

  // A cycle that changes state never advances, even on a coinciding request.
  always_comb begin
    adv_req = 1'b0;
    if (!state_change) begin
      case (state)
        FREE:    adv_req = terminal;
        SINGLE:  adv_req = step_pulse;
        default: adv_req = 1'b0;
      endcase
    end
  end

  assign advance  = adv_req && (enable_mask != '0);
  assign cand_idx = next_index(idx, enable_mask);
  assign idx_next = advance ? cand_idx : idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      presc     <= '0;
      idx       <= '0;
      sel       <= '0;
      sel_valid <= 1'b0;
      tick      <= 1'b0;
      wrap      <= 1'b0;
    end else begin
      state <= nxt_state;
      if (state_change || state != FREE || terminal)
        presc <= '0;
      else
        presc <= presc + DIV_W'(1);
      idx       <= idx_next;
      // With every line masked, the decoder gets line 0 with sel_valid low.
      sel       <= (enable_mask == '0) ? '0 : idx_next;
      sel_valid <= enable_mask[idx_next];
      tick      <= advance;
      wrap      <= advance && (cand_idx <= idx);
    end
  end

  assign a = sel[1];
  assign b = sel[0];

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with TICK_DIV=4.
// Expected selects and pulse timings are computed by hand.
module tb_scan_sequencer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       mode;
  logic       step;
  logic [3:0] enable_mask;
  logic       a;
  logic       b;
  logic       sel_valid;
  logic       tick;
  logic       wrap;
  logic [1:0] ab;

  int total = 0;
  int bad   = 0;

  scan_sequencer #(.TICK_DIV(4), .DIV_W(17)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .mode        (mode),
    .step        (step),
    .enable_mask (enable_mask),
    .a           (a),
    .b           (b),
    .sel_valid   (sel_valid),
    .tick        (tick),
    .wrap        (wrap)
  );

  assign ab = {a, b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_ab(input string tag, input logic [1:0] exp);
    total++;
    assert (ab === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, ab, exp);
    end
  endtask

  // The tick must be absent for gap-1 cycles and then arrive with the given select and wrap.
  task automatic expect_advance(input logic [1:0] exp_ab, input logic exp_wrap, input int gap);
    for (int i = 1; i < gap; i++) begin
      cyc();
      check_bit("early_tick", tick, 1'b0);
    end
    cyc();
    check_bit("tick", tick, 1'b1);
    check_ab("ab_on_tick", exp_ab);
    check_bit("wrap", wrap, exp_wrap);
  endtask

  task automatic wait_tick(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc();
      if (tick === 1'b1) seen = 1'b1;
    end
    check_bit("tick_within_budget", seen, 1'b1);
  endtask

  // Step is held for 'hold' clocks and then released for four clocks.
  // The tick is due after the fourth edge, counting the first edge that samples step high.
  task automatic single_step(input int hold, input logic [1:0] exp_ab, input logic exp_wrap);
    step = 1'b1;
    expect_advance(exp_ab, exp_wrap, 4);
    for (int i = 4; i < hold; i++) begin
      cyc();
      check_bit("held_step_tick", tick, 1'b0);
    end
    step = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check_bit("released_step_tick", tick, 1'b0);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    en          = 1'b0;
    mode        = 1'b0;
    step        = 1'b0;
    enable_mask = 4'b1111;
    #12;
    check_ab("reset_ab", 2'b00);
    check_bit("reset_sel_valid", sel_valid, 1'b0);
    check_bit("reset_tick", tick, 1'b0);
    check_bit("reset_wrap", wrap, 1'b0);

    // Free run over all four lines.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    en    = 1'b1;
    cyc();
    check_bit("free_start_tick", tick, 1'b0);
    check_ab("free_start_ab", 2'b00);
    check_bit("free_start_valid", sel_valid, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      expect_advance(2'(k % 4), (k == 4), 4);
      check_bit("free_valid", sel_valid, 1'b1);
    end

    // Mask 1010 alternates between lines 01 and 11.
    enable_mask = 4'b1010;
    expect_advance(2'b01, 1'b0, 4);
    check_bit("mask_valid", sel_valid, 1'b1);
    expect_advance(2'b11, 1'b0, 4);
    expect_advance(2'b01, 1'b1, 4);
    expect_advance(2'b11, 1'b0, 4);

    enable_mask = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      cyc();
      check_bit("nomask_valid", sel_valid, 1'b0);
      check_ab("nomask_ab", 2'b00);
      check_bit("nomask_tick", tick, 1'b0);
      check_bit("nomask_wrap", wrap, 1'b0);
    end

    // Return to line 00 (3 -> 0 wraps), then switch to single-step.
    enable_mask = 4'b1111;
    wait_tick(8);
    check_ab("realign_ab", 2'b00);
    check_bit("realign_wrap", wrap, 1'b1);
    mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_bit("single_idle_tick", tick, 1'b0);
      check_ab("single_idle_ab", 2'b00);
    end
    single_step(5, 2'b01, 1'b0);
    single_step(4, 2'b10, 1'b0);
    single_step(4, 2'b11, 1'b0);
    single_step(4, 2'b00, 1'b1);

    // A step edge during free run must not add an advance.
    mode = 1'b0;
    step = 1'b1;
    cyc();
    check_bit("mode_switch_tick", tick, 1'b0);
    step = 1'b0;
    expect_advance(2'b01, 1'b0, 4);
    expect_advance(2'b10, 1'b0, 4);

    // Drop en with the prescaler at 2 and hold for five clocks.
    cyc();
    cyc();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check_bit("idle_tick", tick, 1'b0);
      check_ab("idle_ab", 2'b10);
    end
    en = 1'b1;
    cyc();
    check_bit("reenable_tick", tick, 1'b0);
    expect_advance(2'b11, 1'b0, 4);

    // Change mode on the terminal-count cycle.
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_bit("pre_tc_tick", tick, 1'b0);
    end
    mode = 1'b1;
    cyc();
    check_bit("tc_mode_change_tick", tick, 1'b0);
    check_ab("tc_mode_change_ab", 2'b11);
    for (int i = 0; i < 3; i++) begin
      cyc();
      check_bit("single_no_step_tick", tick, 1'b0);
    end

    // With only line 10 enabled, every advance wraps back onto it.
    enable_mask = 4'b0100;
    mode        = 1'b0;
    cyc();
    check_bit("single_line_start_tick", tick, 1'b0);
    expect_advance(2'b10, 1'b1, 4);
    check_bit("single_line_valid", sel_valid, 1'b1);
    expect_advance(2'b10, 1'b1, 4);
    enable_mask = 4'b0000;
    cyc();
    check_bit("cleared_line_valid", sel_valid, 1'b0);

    // Assert asynchronous reset between edges while on line 11.
    enable_mask = 4'b1111;
    wait_tick(8);
    check_ab("pre_reset_ab", 2'b11);
    check_bit("pre_reset_wrap", wrap, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_ab("async_reset_ab", 2'b00);
    check_bit("async_reset_valid", sel_valid, 1'b0);
    check_bit("async_reset_tick", tick, 1'b0);
    check_bit("async_reset_wrap", wrap, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    check_ab("restart_ab", 2'b00);
    check_bit("restart_tick", tick, 1'b0);
    check_bit("restart_valid", sel_valid, 1'b1);
    expect_advance(2'b01, 1'b0, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Generates the 2-bit select {a, b} that drives the downstream 2-to-4 decoder.
- Steps through the four decoder lines in ascending order, either free-running from a prescaler or one line per external step pulse.
- Skips lines that are masked off.
- Provides handshake pulses (tick, wrap) so display or scan logic can latch per-line data in step with the decoder.

Parameters:
- TICK_DIV, 4, clock cycles per advance in free-run mode; must be >= 2.
- DIV_W, 17, prescaler counter width; must satisfy 2**DIV_W >= TICK_DIV.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  sequencer enable
- mode  in  1  0 = free-run (prescaler), 1 = single-step
- step  in  1  asynchronous step request; one advance per rising edge
- enable_mask  in  4  bit i = decoder line i participates in the scan
- a  out  1  select MSB to decoder (line index bit 1)
- b  out  1  select LSB to decoder (line index bit 0)
- sel_valid  out  1  1 = the current {a, b} addresses an enabled line
- tick  out  1  one-cycle pulse in the cycle the new {a, b} first appears
- wrap  out  1  one-cycle pulse coincident with tick when the scan wraps

Behaviour:
- Clock and reset:
  - Single clock domain: clk.
  - rst_n low asynchronously clears all state, with no clock edge needed.
  - Reset values: index=0, a=0, b=0, sel_valid=0, tick=0, wrap=0, prescaler=0, sync flops=0, state=IDLE.
- Line mapping: {a, b} = index, so line d0=00, d1=01, d2=10, d3=11.
- FSM states:
  - IDLE: entered when en=0. Prescaler is held at 0. Index, a and b hold their values. tick=wrap=0.
  - FREE: entered when en=1 and mode=0. Prescaler counts 0..TICK_DIV-1. At terminal count it returns to 0 and requests one advance.
  - SINGLE: entered when en=1 and mode=1. Prescaler is held at 0. Each synchronized rising edge of step requests one advance.
- Transitions:
  - Any state goes to IDLE when en=0.
  - IDLE goes to FREE or SINGLE according to mode when en=1.
  - FREE and SINGLE switch between each other when mode changes.
  - Every state change clears the prescaler. No advance is made in a cycle where the state changes, even if terminal count or a step edge coincides with it.
- Step synchronizer:
  - Two flops, then an edge detect on the second flop.
  - Fixed latency: the advance request is seen 3 clk edges after step is first sampled high.
  - Holding step high produces exactly one advance.
  - Step edges arriving in FREE or IDLE are discarded, not queued.
- Advance:
  - New index = first i in (idx+1, idx+2, idx+3, idx+4) mod 4 with enable_mask[i]=1.
  - If only the current line is enabled, the index stays the same but tick still pulses.
  - a, b and tick are registered together, so the new select and tick appear on the same clk edge after the request.
  - wrap=1 with tick when new index <= old index (this includes the single-enabled-line case).
- Mask handling:
  - enable_mask=0: advance requests are ignored (no tick, no wrap), the index holds, a=b=0 and sel_valid=0.
  - Mask changes take effect at the next advance.
- sel_valid: registered each cycle as enable_mask[next-cycle index]. If the current line becomes masked, sel_valid drops one cycle later and stays 0 until an advance lands on an enabled line.
- Prescaler width: arithmetic is DIV_W bits with no overflow, since it compares equal to TICK_DIV-1 before wrapping.

Decomposition:
- Package scan_pkg:
  - NUM_LINES=4 and SEL_W=2.
  - FSM state encoding: IDLE=2'b00, FREE=2'b01, SINGLE=2'b10.
  - Function next_index(idx, mask).
- Sub-module step_sync: 2-flop synchronizer plus rising-edge detector, with clk and rst_n. It outputs a one-cycle step_pulse.
- Everything else lives in scan_sequencer.

Test Plan:
1. Free run: TICK_DIV=4, mask=1111, en=1, mode=0 after reset. Required: tick every 4 clks; {a,b} 00->01->10->11->00; wrap only on 11->00; sel_valid=1 throughout.
2. Masking: mask=1010, free run. Required: {a,b} 01->11->01->11; wrap on each 11->01; line 00 never selected after the first advance. Then set mask=0000. Required: sel_valid=0, a=b=0, no tick or wrap for 20 clks.
3. Single-step: mode=1, step held high 5 clks. Required: exactly one tick, 3 clks after step is first sampled high, {a,b} 00->01. Then toggle step 3 more times (each low at least 3 clks). Required: 10, 11, 00 with wrap on the last.
4. Mode and enable interplay:
   - Pulse step while mode=0. Required: no extra advance.
   - Drop en mid-count (prescaler=2), hold 5 clks, re-enable. Required: first tick a full 4 clks after en rises; index unchanged while en=0.
   - Change mode in the same cycle as terminal count. Required: no advance.
5. Single line: mask=0100. Required: every advance gives {a,b}=10 with tick=wrap=1. Then clear bit 2. Required: sel_valid drops within 1 clk.
6. Async reset: assert rst_n low between clock edges mid-run at index 11. Required: a=b=sel_valid=tick=wrap=0 immediately with no clk edge; after release, the sequence restarts from 00 with a full TICK_DIV delay.
